// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding arbiter sharing a single memory port between fetch (read) and memory stage (read/write); ARB_FAIR_EN selects round-robin on contention
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          InstrReq,
  input  logic [AW-1:0] InstrAddr,
  output logic [DW-1:0] InstrRdata,
  output logic          InstrValid,
  input  logic          DataReq,
  input  logic          DataWe,
  input  logic [AW-1:0] DataAddr,
  input  logic [DW-1:0] DataWdata,
  output logic [DW-1:0] DataRdata,
  output logic          DataValid,
  output logic          MemReq,
  output logic          MemWe,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWdata,
  input  logic [DW-1:0] MemRdata,
  input  logic          MemReady,
  output logic          StallF,
  output logic          StallM,
  output logic          MemErr
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WAIT_I, WAIT_D, DONE_I, DONE_D} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic last_d, last_d_n, grant_d, tmo, req_n, we_n, err_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n, irdata_n, drdata_n;
  assign grant_d = DataReq && !(FAIR && InstrReq && last_d);
  assign tmo = TIMEOUT_CYCLES != 0 && int'(cnt) == TIMEOUT_CYCLES - 1;
  assign InstrValid = state == DONE_I;
  assign DataValid = state == DONE_D;
  assign StallF = InstrReq && !InstrValid;
  assign StallM = DataReq && !DataValid;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last_d <= 1'b0;
      MemReq <= 1'b0;
      MemWe <= 1'b0;
      MemAddr <= '0;
      MemWdata <= '0;
      InstrRdata <= '0;
      DataRdata <= '0;
      MemErr <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last_d <= last_d_n;
      MemReq <= req_n;
      MemWe <= we_n;
      MemAddr <= addr_n;
      MemWdata <= wdata_n;
      InstrRdata <= irdata_n;
      DataRdata <= drdata_n;
      MemErr <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    last_d_n = last_d;
    req_n = MemReq;
    we_n = MemWe;
    addr_n = MemAddr;
    wdata_n = MemWdata;
    irdata_n = InstrRdata;
    drdata_n = DataRdata;
    err_n = MemErr;
    unique case (state)
      IDLE: if (InstrReq || DataReq) begin
        state_n = grant_d ? WAIT_D : WAIT_I;
        cnt_n = '0;
        req_n = 1'b1;
        we_n = grant_d && DataWe;
        addr_n = grant_d ? DataAddr : InstrAddr;
        wdata_n = grant_d ? DataWdata : MemWdata;
      end
      WAIT_I, WAIT_D: begin
        cnt_n = cnt + CW'(1);
        if (MemReady || tmo) begin
          state_n = state == WAIT_D ? DONE_D : DONE_I;
          cnt_n = '0;
          req_n = 1'b0;
          we_n = 1'b0;
          err_n = MemErr || !MemReady;
          irdata_n = state == WAIT_I ? (MemReady ? MemRdata : '0) : InstrRdata;
          drdata_n = state == WAIT_D ? (MemReady ? MemRdata : '0) : DataRdata;
        end
      end
      default: begin
        state_n = IDLE;
        last_d_n = state == DONE_D;
      end
    endcase
  end
endmodule
